pci_burst_target: RTL and testbench

- Parametrised successor to the single-phase PCI target device: a PCI memory target with an internal word buffer.
- Supports memory read/write bursts with byte enables, configurable DEVSEL timing, initial wait states and disconnect-with-data at the buffer end.
- Sits on the shared AD/CBE bus beside the existing target devices.
- Bus control signals are active-low, per PCI.

---
 rtl/pci_burst_target.sv | 163 ++++++++++++++++
 tb/tb_pci_burst_target.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_burst_target.sv
// PCI memory target with an internal word buffer: bursts with byte enables,
// configurable DEVSEL timing, initial wait states and disconnect-with-data.
module pci_burst_target #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned ADDR_BITS    = 4,
   parameter int unsigned DEVSEL_SPEED = 0,
   parameter int unsigned INIT_WAIT    = 0
) (
   input  logic                 CLK,
   input  logic                 REST,
   input  logic                 FRAME,
   inout  wire  [31:0]          AD,
   input  logic [3:0]           CBE,
   input  logic                 IRDY,
   output logic                 TRDY,
   output logic                 DEVSEL,
   output logic                 STOP,
   output logic [ADDR_BITS:0]   XFER_CNT
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_BUSY, S_DECODE, S_WAIT, S_DATA, S_DISC, S_TURN
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic                 rd_q, rd_d;
   logic [ADDR_BITS:0]   xfer_q, xfer_d;
   logic                 trdy_q, trdy_d;
   logic                 devsel_q, devsel_d;
   logic                 stop_q, stop_d;
   logic                 ad_oe_q, ad_oe_d;
   logic [31:0]          ad_q, ad_d;
   logic                 frame_q;
   logic [31:0]          mem_q [DEPTH];

   logic       addr_phase, addr_hit, rd_sel, xfer, wr_en;
   logic [2:0] wait_len;

   always_comb begin
      addr_phase = (state_q == S_IDLE) && !FRAME && frame_q;
      addr_hit   = (AD[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]) &&
                   ((CBE == 4'b0110) || (CBE == 4'b0111));
      rd_sel     = (state_q == S_IDLE) ? (CBE == 4'b0110) : rd_q;
      // Reads need one turnaround cycle even when no delay is configured.
      wait_len   = (rd_sel && INIT_WAIT == 0 && DEVSEL_SPEED == 0) ? 3'd1 : 3'(INIT_WAIT);
      xfer       = (state_q == S_DATA) && !IRDY && !trdy_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rd_d    = rd_q;
      xfer_d  = xfer_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (addr_phase) begin
               if (addr_hit) begin
                  rd_d   = (CBE == 4'b0110);
                  idx_d  = AD[ADDR_BITS+1:2];
                  xfer_d = '0;
                  if (DEVSEL_SPEED != 0) begin
                     state_d = S_DECODE;
                     cnt_d   = 3'(DEVSEL_SPEED - 1);
                  end else if (wait_len != 3'd0) begin
                     state_d = S_WAIT;
                     cnt_d   = wait_len - 3'd1;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: if (FRAME && IRDY) state_d = S_IDLE;
         S_DECODE: begin
            if (FRAME && IRDY) begin
               state_d = S_IDLE;
            end else if (cnt_q == 3'd0) begin
               if (wait_len != 3'd0) begin
                  state_d = S_WAIT;
                  cnt_d   = wait_len - 3'd1;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_DATA;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_DATA: begin
            if (xfer) begin
               wr_en  = !rd_q;
               xfer_d = xfer_q + 1'b1;
               if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
               if (FRAME)                  state_d = S_TURN;
               else if (idx_q == LAST_IDX) state_d = S_DISC;
            end
         end
         S_DISC: if (FRAME) state_d = S_TURN;
         S_TURN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      devsel_d = !(state_d inside {S_WAIT, S_DATA, S_DISC});
      trdy_d   = !(state_d == S_DATA);
      // STOP goes out with the TRDY of the last buffer word and holds through DISC.
      stop_d   = !((state_d == S_DISC) ||
                   (state_d == S_DATA && idx_d == LAST_IDX && (!FRAME || !stop_q)));
      ad_oe_d  = rd_q && (state_q inside {S_DECODE, S_WAIT, S_DATA}) &&
                         (state_d inside {S_DECODE, S_WAIT, S_DATA});
      ad_d     = mem_q[idx_d];
   end

   always_ff @(posedge CLK) begin
      frame_q <= FRAME;
      if (REST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         rd_q     <= 1'b0;
         xfer_q   <= '0;
         trdy_q   <= 1'b1;
         devsel_q <= 1'b1;
         stop_q   <= 1'b1;
         ad_oe_q  <= 1'b0;
         ad_q     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rd_q     <= rd_d;
         xfer_q   <= xfer_d;
         trdy_q   <= trdy_d;
         devsel_q <= devsel_d;
         stop_q   <= stop_d;
         ad_oe_q  <= ad_oe_d;
         ad_q     <= ad_d;
         if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++)
               if (!CBE[b]) mem_q[idx_q][8*b +: 8] <= AD[8*b +: 8];
         end
      end
   end

   assign TRDY     = trdy_q;
   assign DEVSEL   = devsel_q;
   assign STOP     = stop_q;
   assign XFER_CNT = xfer_q;
   assign AD       = ad_oe_q ? ad_q : 'z;

endmodule

// File: tb/tb_pci_burst_target.sv
// Bench for pci_burst_target: two targets (fast/no-wait and medium/2-wait) on a
// shared bus, a bus-master task and a read-data scoreboard against a memory model.
module tb_pci_burst_target;

   logic        clk, rest, frame, irdy, tb_oe;
   logic [3:0]  cbe;
   logic [31:0] tb_ad;
   wire  [31:0] ad0, ad1;
   logic        trdy0, devsel0, stop0, trdy1, devsel1, stop1;
   logic [4:0]  xfer0, xfer1;

   int total = 0;
   int bad   = 0;
   int tsel  = 0;
   logic [31:0] model [2][16];
   logic [31:0] wdata [16];
   logic [3:0]  wbe   [16];
   logic [31:0] sb [$];

   assign ad0 = tb_oe ? tb_ad : 'z;
   assign ad1 = tb_oe ? tb_ad : 'z;

   wire        cur_trdy   = (tsel == 1) ? trdy1   : trdy0;
   wire        cur_devsel = (tsel == 1) ? devsel1 : devsel0;
   wire        cur_stop   = (tsel == 1) ? stop1   : stop0;
   wire [31:0] cur_ad     = (tsel == 1) ? ad1     : ad0;

   pci_burst_target #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(4), .DEVSEL_SPEED(0), .INIT_WAIT(0)) u_dut0 (
      .CLK(clk), .REST(rest), .FRAME(frame), .AD(ad0), .CBE(cbe), .IRDY(irdy),
      .TRDY(trdy0), .DEVSEL(devsel0), .STOP(stop0), .XFER_CNT(xfer0));

   pci_burst_target #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .DEVSEL_SPEED(1), .INIT_WAIT(2)) u_dut1 (
      .CLK(clk), .REST(rest), .FRAME(frame), .AD(ad1), .CBE(cbe), .IRDY(irdy),
      .TRDY(trdy1), .DEVSEL(devsel1), .STOP(stop1), .XFER_CNT(xfer1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 16; w++) model[s][w] = '0;
   endtask

   // Bus master: one transaction; reads pop expectations, writes update the model.
   task automatic master(input int sel, input logic [31:0] addr, input bit rd, input int n,
                         input int stall_at, output int devsel_at, output int trdy_at,
                         output int nx);
      int idx;
      int i;
      bit stalled;
      bit done;
      logic [31:0] exp;
      idx = int'(addr[5:2]);
      tsel = sel;
      if (rd)
         for (int k = 0; k < n && idx + k < 16; k++) sb.push_back(model[sel][idx+k]);
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = addr; cbe = rd ? 4'b0110 : 4'b0111;
      @(posedge clk);
      devsel_at = -1; trdy_at = -1; i = 0; stalled = 1'b0; done = 1'b0;
      for (int j = 1; j <= 40 && !done; j++) begin
         @(negedge clk);
         if (!stalled && i == stall_at) begin
            irdy = 1'b1; stalled = 1'b1;
         end else begin
            irdy = 1'b0; frame = (i == n - 1);
         end
         tb_oe = !rd; tb_ad = wdata[i]; cbe = rd ? 4'b0000 : wbe[i];
         if (devsel_at < 0 && cur_devsel == 1'b0) devsel_at = j;
         if (trdy_at < 0 && cur_trdy == 1'b0) trdy_at = j;
         if (!irdy && !cur_trdy) begin
            if (rd) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL read_extra: got %h expected no transfer", cur_ad);
               end else begin
                  exp = sb.pop_front();
                  if (cur_ad !== exp) begin
                     bad++;
                     $display("FAIL read_data idx=%0d: got %h expected %h", idx, cur_ad, exp);
                  end
               end
            end else begin
               for (int b = 0; b < 4; b++)
                  if (!wbe[i][b]) model[sel][idx][8*b +: 8] = wdata[i][8*b +: 8];
            end
            if (idx < 15) idx++;
            i++;
            if (frame || !cur_stop) done = 1'b1;
         end
         @(posedge clk);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL master_timeout: got %0d transfers expected %0d", i, n);
      end
      nx = i;
      @(negedge clk);
      frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0; cbe = 4'b0000;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      rest = 1'b1; frame = 1'b1; irdy = 1'b1; cbe = 4'b0000; tb_oe = 1'b0; tb_ad = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({trdy0, devsel0, stop0, xfer0} !== {3'b111, 5'd0}) begin
         bad++;
         $display("FAIL reset_dut0: got %b expected %b", {trdy0, devsel0, stop0, xfer0}, {3'b111, 5'd0});
      end
      total++;
      if ({trdy1, devsel1, stop1, xfer1} !== {3'b111, 5'd0}) begin
         bad++;
         $display("FAIL reset_dut1: got %b expected %b", {trdy1, devsel1, stop1, xfer1}, {3'b111, 5'd0});
      end
      rest = 1'b0;
      clear_model();
   endtask

   task automatic test_single_write_read();
      int ds, ts, nx;
      wdata[0] = 32'hDEAD_BEEF; wbe[0] = 4'b0000;
      master(0, 32'h0000_0004, 1'b0, 1, -1, ds, ts, nx);
      total++;
      if (ds !== 1) begin bad++; $display("FAIL wr_devsel_at: got %0d expected 1", ds); end
      total++;
      if (xfer0 !== 5'd1) begin bad++; $display("FAIL wr_xfer_cnt: got %0d expected 1", xfer0); end
      master(0, 32'h0000_0004, 1'b1, 1, -1, ds, ts, nx);
      total++;
      if (ts !== 2) begin bad++; $display("FAIL rd_trdy_at: got %0d expected 2", ts); end
      total++;
      if (xfer0 !== 5'd1) begin bad++; $display("FAIL rd_xfer_cnt: got %0d expected 1", xfer0); end
   endtask

   task automatic test_byte_enables();
      int ds, ts, nx;
      wdata[0] = 32'h1122_3344; wbe[0] = 4'b1100;
      master(0, 32'h0000_0004, 1'b0, 1, -1, ds, ts, nx);
      total++;
      if (model[0][1] !== 32'hDEAD_3344) begin
         bad++;
         $display("FAIL be_model: got %h expected %h", model[0][1], 32'hDEAD_3344);
      end
      master(0, 32'h0000_0004, 1'b1, 1, -1, ds, ts, nx);
   endtask

   task automatic test_burst_stall();
      int ds, ts, nx;
      for (int k = 0; k < 4; k++) begin
         wdata[k] = 32'hA5A5_0000 + 32'(k * 32'h0101_0101);
         wbe[k]   = 4'b0000;
      end
      master(1, 32'h0000_1000, 1'b0, 4, 2, ds, ts, nx);
      total++;
      if (ds !== 2) begin bad++; $display("FAIL burst_devsel_at: got %0d expected 2", ds); end
      total++;
      if (ts !== 4) begin bad++; $display("FAIL burst_trdy_at: got %0d expected 4", ts); end
      total++;
      if (nx !== 4) begin bad++; $display("FAIL burst_nxfer: got %0d expected 4", nx); end
      total++;
      if (xfer1 !== 5'd4) begin bad++; $display("FAIL burst_xfer_cnt: got %0d expected 4", xfer1); end
      master(1, 32'h0000_1000, 1'b1, 5, -1, ds, ts, nx);
      total++;
      if (xfer1 !== 5'd5) begin bad++; $display("FAIL burst_rd_xfer_cnt: got %0d expected 5", xfer1); end
   endtask

   task automatic test_disconnect();
      int ds, ts, nx;
      logic [31:0] exp;
      wdata[0] = 32'h0E0E_0E0E; wdata[1] = 32'hF0F0_F0F0; wbe[0] = 4'b0000; wbe[1] = 4'b0000;
      master(0, 32'h0000_0038, 1'b0, 2, -1, ds, ts, nx);
      total++;
      if (nx !== 2) begin bad++; $display("FAIL disc_prewrite: got %0d expected 2", nx); end
      tsel = 0;
      sb.push_back(model[0][14]);
      sb.push_back(model[0][15]);
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = 32'h0000_0038; cbe = 4'b0110;
      @(posedge clk);
      @(negedge clk);
      irdy = 1'b0; tb_oe = 1'b0; cbe = 4'b0000;
      total++;
      if ({devsel0, trdy0, stop0} !== 3'b011) begin
         bad++; $display("FAIL disc_turnaround: got %b expected 011", {devsel0, trdy0, stop0});
      end
      for (int w = 0; w < 2; w++) begin
         @(posedge clk);
         @(negedge clk);
         exp = sb.pop_front();
         total++;
         if ({trdy0, stop0, ad0} !== {1'b0, (w == 1) ? 1'b0 : 1'b1, exp}) begin
            bad++;
            $display("FAIL disc_data%0d: got trdy=%b stop=%b ad=%h expected trdy=0 stop=%b ad=%h",
                     w, trdy0, stop0, ad0, (w == 1) ? 1'b0 : 1'b1, exp);
         end
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({devsel0, trdy0, stop0} !== 3'b010) begin
            bad++; $display("FAIL disc_hold%0d: got %b expected 010", c, {devsel0, trdy0, stop0});
         end
      end
      frame = 1'b1; irdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({devsel0, trdy0, stop0, xfer0} !== {3'b111, 5'd2}) begin
         bad++; $display("FAIL disc_turn: got %b expected %b", {devsel0, trdy0, stop0, xfer0}, {3'b111, 5'd2});
      end
      @(posedge clk);
   endtask

   task automatic test_miss();
      int ds, ts, nx;
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = 32'h1000_0000; cbe = 4'b0111;
      for (int j = 1; j <= 8; j++) begin
         @(posedge clk);
         @(negedge clk);
         if (j == 1) begin tb_ad = 32'hFFFF_FFFF; cbe = 4'b0000; irdy = 1'b0; end
         if (j == 6) frame = 1'b1;
         if (j == 7) irdy = 1'b1;
         total++;
         if ({trdy0, devsel0, stop0, trdy1, devsel1, stop1} !== 6'b111111) begin
            bad++;
            $display("FAIL miss_quiet%0d: got %b expected 111111", j, {trdy0, devsel0, stop0, trdy1, devsel1, stop1});
         end
      end
      tb_oe = 1'b0;
      total++;
      if (xfer0 !== 5'd2) begin bad++; $display("FAIL miss_xfer_hold: got %0d expected 2", xfer0); end
      repeat (2) @(posedge clk);
      master(0, 32'h0000_0000, 1'b1, 2, -1, ds, ts, nx);
      master(1, 32'h0000_1000, 1'b1, 1, -1, ds, ts, nx);
   endtask

   task automatic test_reset_mid_burst();
      int ds, ts, nx;
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = 32'h0000_0000; cbe = 4'b0111;
      @(posedge clk);
      @(negedge clk);
      tb_ad = 32'hAAAA_5555; cbe = 4'b0000; irdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rest = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({trdy0, devsel0, stop0, xfer0} !== {3'b111, 5'd0}) begin
         bad++;
         $display("FAIL midreset_dut0: got %b expected %b", {trdy0, devsel0, stop0, xfer0}, {3'b111, 5'd0});
      end
      rest = 1'b0; frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0;
      clear_model();
      @(posedge clk);
      master(0, 32'h0000_0000, 1'b1, 2, -1, ds, ts, nx);
      master(1, 32'h0000_1000, 1'b1, 1, -1, ds, ts, nx);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin wdata[k] = '0; wbe[k] = 4'b1111; end
      test_reset();
      test_single_write_read();
      test_byte_enables();
      test_burst_stall();
      test_disconnect();
      test_miss();
      test_reset_mid_burst();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
